// File: rtl/fwd_source_pkg.sv
// Shared types and constants for the EX/MEM forwarding source stage.
// Optional skid storage is enabled by defining FWD_SOURCE_SKID_EN.
package fwd_source_pkg;

   localparam int FWD_DW = 16;
   localparam int FWD_RW = 4;

   localparam logic [1:0] RW_NONE    = 2'd0;
   localparam logic [1:0] RW_OP1     = 2'd1;
   localparam logic [1:0] RW_OP1_OP2 = 2'd2;
   localparam logic [1:0] RW_OP1_R15 = 2'd3;

   typedef struct packed {
      logic [FWD_RW-1:0] op1;
      logic [FWD_RW-1:0] op2;
      logic [FWD_DW-1:0] op1data;
      logic [FWD_DW-1:0] op2data;
      logic [FWD_DW-1:0] r15data;
      logic [1:0]        rWrite;
   } fwd_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } fwd_state_t;

   // An empty bus must never advertise a write, whatever the head still holds.
   function automatic logic [1:0] gate_rwrite(input logic valid, input logic [1:0] code);
      return valid ? code : RW_NONE;
   endfunction

endpackage

// File: rtl/fwd_source_stage_entry_reg.sv
// One loadable forwarding entry register, cleared by asynchronous reset.
module fwd_entry_reg #(
   parameter int W = 62
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_en,
   input  logic [W-1:0] load_data,
   output logic [W-1:0] entry
);

   logic [W-1:0] entry_q;
   logic [W-1:0] entry_d;

   always_comb begin
      entry_d = load_en ? load_data : entry_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_q <= '0;
      else     entry_q <= entry_d;
   end

   assign entry = entry_q;

endmodule

// File: rtl/fwd_source_stage.sv
// EX/MEM register driving the forwarding bus; define FWD_SOURCE_SKID_EN for a
// second (skid) entry and a registered ex_ready with no MEM-to-EX ready path.
module fwd_source_stage
   import fwd_source_pkg::*;
#(
   parameter int DW = FWD_DW,
   parameter int RW = FWD_RW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [RW-1:0] ex_op1,
   input  logic [RW-1:0] ex_op2,
   input  logic [DW-1:0] ex_op1data,
   input  logic [DW-1:0] ex_op2data,
   input  logic [DW-1:0] ex_r15data,
   input  logic [1:0]    ex_rWrite,
   input  logic          flush,
   input  logic          mem_ready,
   output logic          mem_valid,
   output logic [RW-1:0] memop1,
   output logic [RW-1:0] memop2,
   output logic [DW-1:0] memop1data,
   output logic [DW-1:0] memop2data,
   output logic [DW-1:0] memr15data,
   output logic [1:0]    rWrite
);

   typedef struct packed {
      logic [RW-1:0] op1;
      logic [RW-1:0] op2;
      logic [DW-1:0] op1data;
      logic [DW-1:0] op2data;
      logic [DW-1:0] r15data;
      logic [1:0]    rWrite;
   } entry_t;

   localparam int EW = $bits(entry_t);

   fwd_state_t state_q, state_d;
   logic       mem_valid_q, mem_valid_d;
   logic       in_xfer, out_xfer;
   logic       head_load;
   entry_t     ex_entry, head_entry, head_load_data;

   assign ex_entry = '{op1: ex_op1, op2: ex_op2, op1data: ex_op1data,
                       op2data: ex_op2data, r15data: ex_r15data, rWrite: ex_rWrite};

`ifdef FWD_SOURCE_SKID_EN
   logic   ex_ready_q, ex_ready_d;
   logic   skid_load, head_from_skid;
   entry_t skid_entry;

   assign ex_ready = ex_ready_q;
`else
   assign ex_ready = (state_q == ST_EMPTY) | mem_ready;
`endif

   assign in_xfer  = ex_valid & ex_ready;
   assign out_xfer = mem_valid_q & mem_ready;

   // Flush overrides every other event and drops the same-cycle incoming result.
   always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
`ifdef FWD_SOURCE_SKID_EN
      skid_load      = 1'b0;
      head_from_skid = 1'b0;
`endif
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d   = ST_ONE;
                  head_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  head_load = 1'b1;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
`ifdef FWD_SOURCE_SKID_EN
               end else if (in_xfer) begin
                  state_d   = ST_TWO;
                  skid_load = 1'b1;
`endif
               end
            end
`ifdef FWD_SOURCE_SKID_EN
            ST_TWO: begin
               if (out_xfer) begin
                  state_d        = ST_ONE;
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
               end
            end
`endif
            default: state_d = ST_EMPTY;
         endcase
      end
      mem_valid_d = (state_d != ST_EMPTY);
`ifdef FWD_SOURCE_SKID_EN
      ex_ready_d  = (state_d != ST_TWO);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         mem_valid_q <= 1'b0;
`ifdef FWD_SOURCE_SKID_EN
         ex_ready_q  <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
`ifdef FWD_SOURCE_SKID_EN
         ex_ready_q  <= ex_ready_d;
`endif
      end
   end

`ifdef FWD_SOURCE_SKID_EN
   assign head_load_data = head_from_skid ? skid_entry : ex_entry;

   fwd_entry_reg #(.W(EW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load_en   (skid_load),
      .load_data (ex_entry),
      .entry     (skid_entry)
   );
`else
   assign head_load_data = ex_entry;
`endif

   fwd_entry_reg #(.W(EW)) u_head (
      .clk       (clk),
      .rst       (rst),
      .load_en   (head_load),
      .load_data (head_load_data),
      .entry     (head_entry)
   );

   assign mem_valid  = mem_valid_q;
   assign memop1     = head_entry.op1;
   assign memop2     = head_entry.op2;
   assign memop1data = head_entry.op1data;
   assign memop2data = head_entry.op2data;
   assign memr15data = head_entry.r15data;
   assign rWrite     = gate_rwrite(mem_valid_q, head_entry.rWrite);

endmodule

// File: tb/tb_fwd_source_stage.sv
// Randomized bench for fwd_source_stage checked against a queue-based model
// whose capacity and ready rule follow FWD_SOURCE_SKID_EN.
module tb_fwd_source_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, flush, mem_ready, mem_valid;
   logic [3:0]  ex_op1, ex_op2, memop1, memop2;
   logic [15:0] ex_op1data, ex_op2data, ex_r15data;
   logic [15:0] memop1data, memop2data, memr15data;
   logic [1:0]  ex_rWrite, rWrite;

   typedef struct {
      logic [3:0]  op1;
      logic [3:0]  op2;
      logic [15:0] d1;
      logic [15:0] d2;
      logic [15:0] d15;
      logic [1:0]  rw;
   } ent_t;

   ent_t q[$];
   int   assertCount = 0;
   int   failCount   = 0;

`ifdef FWD_SOURCE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   always #5 clk = ~clk;

   fwd_source_stage dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_op1     (ex_op1),
      .ex_op2     (ex_op2),
      .ex_op1data (ex_op1data),
      .ex_op2data (ex_op2data),
      .ex_r15data (ex_r15data),
      .ex_rWrite  (ex_rWrite),
      .flush      (flush),
      .mem_ready  (mem_ready),
      .mem_valid  (mem_valid),
      .memop1     (memop1),
      .memop2     (memop2),
      .memop1data (memop1data),
      .memop2data (memop2data),
      .memr15data (memr15data),
      .rWrite     (rWrite)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit modelReady();
      if (SKID) return q.size() < 2;
      return (q.size() == 0) || mem_ready;
   endfunction

   task automatic checkBus();
      checkOutput("ex_ready", {31'd0, ex_ready}, {31'd0, modelReady()});
      checkOutput("mem_valid", {31'd0, mem_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
         checkOutput("memop1", {28'd0, memop1}, {28'd0, q[0].op1});
         checkOutput("memop2", {28'd0, memop2}, {28'd0, q[0].op2});
         checkOutput("memop1data", {16'd0, memop1data}, {16'd0, q[0].d1});
         checkOutput("memop2data", {16'd0, memop2data}, {16'd0, q[0].d2});
         checkOutput("memr15data", {16'd0, memr15data}, {16'd0, q[0].d15});
         checkOutput("rWrite", {30'd0, rWrite}, {30'd0, q[0].rw});
      end else begin
         checkOutput("rWrite_idle", {30'd0, rWrite}, 32'd0);
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      checkOutput("rst_rWrite", {30'd0, rWrite}, 32'd0);
      checkOutput("rst_memop1", {28'd0, memop1}, 32'd0);
      checkOutput("rst_memop2", {28'd0, memop2}, 32'd0);
      checkOutput("rst_op1data", {16'd0, memop1data}, 32'd0);
      checkOutput("rst_op2data", {16'd0, memop2data}, 32'd0);
      checkOutput("rst_r15data", {16'd0, memr15data}, 32'd0);
   endtask

   // Drive one cycle, check the pre-edge bus, then advance the model over the edge.
   task automatic applyStimulus(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                                input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d15,
                                input logic [1:0] rw, input logic fl, input logic mr);
      bit   rdy;
      ent_t e;
      ex_valid = v;  ex_op1 = o1;  ex_op2 = o2;
      ex_op1data = d1;  ex_op2data = d2;  ex_r15data = d15;
      ex_rWrite = rw;  flush = fl;  mem_ready = mr;
      #1;
      checkBus();
      rdy = modelReady();
      e = '{op1: o1, op2: o2, d1: d1, d2: d2, d15: d15, rw: rw};
      if (fl) begin
         q.delete();
      end else begin
         if (q.size() != 0 && mr) void'(q.pop_front());
         if (v && rdy) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic mr);
      applyStimulus(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0, mr);
   endtask

   initial begin
      rst = 1'b1;
      ex_valid = 1'b0;  ex_op1 = '0;  ex_op2 = '0;
      ex_op1data = '0;  ex_op2data = '0;  ex_r15data = '0;
      ex_rWrite = '0;  flush = 1'b0;  mem_ready = 1'b0;
      #12;
      checkResetState();
      checkOutput("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] streaming");
      applyStimulus(1'b1, 4'd5, 4'd0, 16'haaaa, 16'h0, 16'h0, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd6, 4'd7, 16'hbbbb, 16'h0c0c, 16'h0, 2'd2, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      $display("[TB] r15 write");
      applyStimulus(1'b1, 4'hf, 4'h0, 16'h0, 16'h0, 16'h1234, 2'd3, 1'b0, 1'b1);
      idle(1'b0);
      idle(1'b1);

      $display("[TB] stall");
      applyStimulus(1'b1, 4'd1, 4'd2, 16'h1111, 16'h2222, 16'h3333, 2'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd3, 4'd4, 16'h4444, 16'h5555, 16'h6666, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd8, 4'd9, 16'h7777, 16'h8888, 16'h9999, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 4'd8, 4'd9, 16'h7777, 16'h8888, 16'h9999, 2'd0, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      $display("[TB] flush with incoming");
      applyStimulus(1'b1, 4'd10, 4'd11, 16'hcafe, 16'hbeef, 16'hf00d, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd12, 4'd13, 16'hdead, 16'hface, 16'hfeed, 2'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd14, 4'd1, 16'h0bad, 16'h0ace, 16'h0dad, 2'd1, 1'b1, 1'b0);
      idle(1'b0);
      idle(1'b1);

      $display("[TB] reset mid-cycle");
      applyStimulus(1'b1, 4'd4, 4'd5, 16'h5a5a, 16'ha5a5, 16'h0f0f, 2'd2, 1'b0, 1'b0);
      ex_valid = 1'b0;
      mem_ready = 1'b0;
      #1;
      checkOutput("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
      rst = 1'b1;
      #1;
      checkResetState();
      q.delete();
      rst = 1'b0;
      #1;
      idle(1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       16'($urandom), 16'($urandom), 16'($urandom),
                       2'($urandom_range(0, 3)),
                       ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 9) < 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
